// File: rtl/mipsfpga_dma_regs_if.sv
// AHB-Lite slave-side bus bundle for the DMA descriptor register bank.
interface mipsfpga_dma_regs_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/mipsfpga_dma_regs.sv
// DMA job descriptor / control / status registers on AHB-Lite, with the
// start handshake towards the DMA engine and the CPU completion interrupt.
module mipsfpga_dma_regs #(
  parameter int unsigned FIFO_DEPTH = 256
) (
  input  logic                      CPU_CLK,
  input  logic                      CPU_RESETn,
  mipsfpga_dma_regs_if.slave        ahb,
  output logic                      DMA_INTERRUPT,
  input  logic                      CLEAR_START,
  input  logic                      DMA_DONE,
  output logic                      DMA_IRQ
);
  localparam int unsigned DW = 32;
  localparam logic [2:0] OFF_SIZE   = 3'd0;
  localparam logic [2:0] OFF_SRC    = 3'd1;
  localparam logic [2:0] OFF_DST    = 3'd2;
  localparam logic [2:0] OFF_ED     = 3'd3;
  localparam logic [2:0] OFF_KEYHI  = 3'd4;
  localparam logic [2:0] OFF_KEYLO  = 3'd5;
  localparam logic [2:0] OFF_CTRL   = 3'd6;
  localparam logic [2:0] OFF_STATUS = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_BUSY} state_t;

  state_t          r_state, w_next;
  logic            r_valid, r_write;
  logic [2:0]      r_addr;
  logic [DW-1:0]   r_size, r_src, r_dst, r_keyhi, r_keylo;
  logic [1:0]      r_ed;
  logic            r_irq_en, r_done, r_err, r_dma_int, r_irq;
  logic [DW-1:0]   w_rdata;
  logic            w_accept, w_wr, w_wr_desc, w_wr_err, w_status_wr;
  logic            w_start_req, w_desc_ok, w_start_ok, w_start_err, w_done_set;
  logic            w_unused;

  assign w_accept    = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
  assign w_wr        = r_valid & r_write;
  assign w_wr_desc   = w_wr & (r_addr <= OFF_KEYLO);
  assign w_wr_err    = w_wr_desc & (r_state != S_IDLE);
  assign w_status_wr = w_wr & (r_addr == OFF_STATUS);
  assign w_start_req = w_wr & (r_addr == OFF_CTRL) & ahb.HWDATA[0];
  // DES works on 64-bit pairs, so an encrypt/decrypt job needs an even word count
  assign w_desc_ok   = (r_size != '0) & ~((r_ed != 2'b00) & r_size[0]);
  assign w_unused    = ^{ahb.HSIZE, ahb.HADDR[31:5], ahb.HADDR[1:0]};

  // Address phase capture
  always_ff @(posedge CPU_CLK or negedge CPU_RESETn) begin
    if (!CPU_RESETn) begin
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_addr  <= ahb.HADDR[4:2];
        r_write <= ahb.HWRITE;
      end
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RESETn) begin
    if (!CPU_RESETn) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_start_ok  = 1'b0;
    w_start_err = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_req) begin
          if (w_desc_ok) begin
            w_next     = S_PENDING;
            w_start_ok = 1'b1;
          end else begin
            w_start_err = 1'b1;
          end
        end
      end
      S_PENDING: begin
        w_start_err = w_start_req;
        if (CLEAR_START) w_next = S_BUSY;
      end
      S_BUSY: begin
        w_start_err = w_start_req;
        if (DMA_DONE) begin
          w_next     = S_IDLE;
          w_done_set = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Descriptor is frozen while the engine owns it
  always_ff @(posedge CPU_CLK or negedge CPU_RESETn) begin
    if (!CPU_RESETn) begin
      r_size  <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_ed    <= '0;
      r_keyhi <= '0;
      r_keylo <= '0;
    end else if (w_wr_desc && (r_state == S_IDLE)) begin
      case (r_addr)
        OFF_SIZE:  r_size  <= (ahb.HWDATA > DW'(FIFO_DEPTH)) ? DW'(FIFO_DEPTH) : ahb.HWDATA;
        OFF_SRC:   r_src   <= ahb.HWDATA;
        OFF_DST:   r_dst   <= ahb.HWDATA;
        OFF_ED:    r_ed    <= ahb.HWDATA[1:0];
        OFF_KEYHI: r_keyhi <= ahb.HWDATA;
        OFF_KEYLO: r_keylo <= ahb.HWDATA;
        default:   ;
      endcase
    end
  end

  // Control/status; set events take priority over write-1-to-clear
  always_ff @(posedge CPU_CLK or negedge CPU_RESETn) begin
    if (!CPU_RESETn) begin
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_dma_int <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr && (r_addr == OFF_CTRL)) r_irq_en <= ahb.HWDATA[1];
      r_done    <= w_done_set | (r_done & ~(w_status_wr & ahb.HWDATA[2]) & ~w_start_ok);
      r_err     <= w_start_err | w_wr_err | (r_err & ~(w_status_wr & ahb.HWDATA[3]));
      r_dma_int <= (w_next == S_PENDING);
      r_irq     <= r_done & r_irq_en;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_valid && !r_write) begin
      case (r_addr)
        OFF_SIZE:   w_rdata = r_size;
        OFF_SRC:    w_rdata = r_src;
        OFF_DST:    w_rdata = r_dst;
        OFF_ED:     w_rdata = DW'(r_ed);
        OFF_KEYHI:  w_rdata = r_keyhi;
        OFF_KEYLO:  w_rdata = r_keylo;
        OFF_CTRL:   w_rdata = DW'({r_irq_en, 1'b0});
        OFF_STATUS: w_rdata = DW'({r_err, r_done, r_state == S_BUSY, r_state == S_PENDING});
        default:    w_rdata = '0;
      endcase
    end
  end

  assign ahb.HRDATA    = w_rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign DMA_INTERRUPT = r_dma_int;
  assign DMA_IRQ       = r_irq;
endmodule

// File: tb/tb_mipsfpga_dma_regs.sv
// Directed bench for mipsfpga_dma_regs: pipelined AHB reads checked through a
// scoreboard queue, plus direct checks of the engine handshake and interrupts.
module tb_mipsfpga_dma_regs;
  localparam logic [31:0] BASE = 32'h1F30_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic clear_start, dma_done;
  logic dma_int, dma_irq;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] sb_exp[$];
  string       sb_tag[$];
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;
  logic [31:0] prev_wdata = '0;

  mipsfpga_dma_regs_if ahb();

  mipsfpga_dma_regs #(.FIFO_DEPTH(256)) dut (
    .CPU_CLK       (clk),
    .CPU_RESETn    (rst_n),
    .ahb           (ahb.slave),
    .DMA_INTERRUPT (dma_int),
    .CLEAR_START   (clear_start),
    .DMA_DONE      (dma_done),
    .DMA_IRQ       (dma_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop();
    logic [31:0] e;
    string       t;
    if (sb_exp.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_underflow: observed read data %h with no expectation", ahb.HRDATA);
    end else begin
      e = sb_exp.pop_front();
      t = sb_tag.pop_front();
      chk(t, ahb.HRDATA, e);
    end
  endtask

  task automatic drive_idle();
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HWRITE = 1'b0;
    ahb.HADDR  = BASE;
    ahb.HWDATA = prev_wr ? prev_wdata : 32'h0;
  endtask

  // One bus cycle: drive an address phase (and the previous write's data),
  // compare the previous read's data phase at the falling edge.
  task automatic step(input bit xfer, input bit wr, input logic [4:0] off,
                      input logic [31:0] data, input logic [31:0] exp, input string tag);
    ahb.HSEL   = xfer;
    ahb.HTRANS = xfer ? 2'b10 : 2'b00;
    ahb.HWRITE = wr;
    ahb.HADDR  = BASE | 32'(off);
    ahb.HSIZE  = 3'b010;
    ahb.HREADY = 1'b1;
    ahb.HWDATA = prev_wr ? prev_wdata : 32'h0;
    if (xfer && !wr) begin
      sb_exp.push_back(exp);
      sb_tag.push_back(tag);
    end
    @(negedge clk);
    if (prev_rd) sb_pop();
    chk("hreadyout_hresp", 32'({ahb.HREADYOUT, ahb.HRESP}), 32'h2);
    @(posedge clk);
    #1;
    prev_rd    = xfer & ~wr;
    prev_wr    = xfer & wr;
    prev_wdata = data;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] data);
    step(1'b1, 1'b1, off, data, 32'h0, "");
  endtask

  task automatic rd(input logic [4:0] off, input logic [31:0] exp, input string tag);
    step(1'b1, 1'b0, off, 32'h0, exp, tag);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'h0, 32'h0, 32'h0, "");
  endtask

  task automatic pulse_clear();
    clear_start = 1'b1;
    idle();
    clear_start = 1'b0;
  endtask

  task automatic pulse_done();
    dma_done = 1'b1;
    idle();
    dma_done = 1'b0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 8; i++) rd(5'(i * 4), 32'h0, tag);
    idle();
  endtask

  initial begin
    rst_n       = 1'b0;
    clear_start = 1'b0;
    dma_done    = 1'b0;
    ahb.HSIZE   = 3'b010;
    ahb.HREADY  = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_dma_int", 32'(dma_int), 32'h0);
    chk("reset_dma_irq", 32'(dma_irq), 32'h0);
    chk("reset_hrdata", ahb.HRDATA, 32'h0);
    read_all_zero("reset_reg");

    // Back-to-back writes then back-to-back reads; SIZE saturates at FIFO_DEPTH
    wr(5'h00, 32'd4); wr(5'h04, 32'h8000_0100); wr(5'h08, 32'h8000_0200); wr(5'h0C, 32'h0);
    rd(5'h00, 32'd4, "size"); rd(5'h04, 32'h8000_0100, "src");
    rd(5'h08, 32'h8000_0200, "dst"); rd(5'h0C, 32'h0, "ed");
    wr(5'h10, 32'hA5A5_1234); rd(5'h10, 32'hA5A5_1234, "keyhi_raw");
    wr(5'h00, 32'd300); rd(5'h00, 32'd256, "size_clamp");
    wr(5'h00, 32'd257); rd(5'h00, 32'd256, "size_clamp_edge");
    wr(5'h00, 32'd4); rd(5'h00, 32'd4, "size_restore");
    idle();

    // Full job with interrupt enabled
    wr(5'h18, 32'h3);
    chk("dma_int_not_yet", 32'(dma_int), 32'h0);
    idle();
    chk("dma_int_set", 32'(dma_int), 32'h1);
    rd(5'h1C, 32'h1, "status_pending"); rd(5'h18, 32'h2, "ctrl_read"); idle();
    pulse_clear();
    chk("dma_int_clear", 32'(dma_int), 32'h0);
    rd(5'h1C, 32'h2, "status_busy"); idle();
    pulse_done();
    chk("dma_irq_lag", 32'(dma_irq), 32'h0);
    idle();
    chk("dma_irq_set", 32'(dma_irq), 32'h1);
    rd(5'h1C, 32'h4, "status_done"); idle();
    wr(5'h1C, 32'h4); idle(); idle();
    chk("dma_irq_clear", 32'(dma_irq), 32'h0);
    rd(5'h1C, 32'h0, "status_w1c"); idle();

    // Descriptor and START writes while busy are dropped and flag ERR
    wr(5'h18, 32'h1); idle();
    pulse_clear();
    wr(5'h04, 32'hDEAD_BEEF); wr(5'h18, 32'h1); idle();
    chk("busy_no_restart", 32'(dma_int), 32'h0);
    rd(5'h04, 32'h8000_0100, "src_frozen"); rd(5'h1C, 32'hA, "status_busy_err"); idle();
    pulse_done();
    wr(5'h1C, 32'hC); idle();
    rd(5'h1C, 32'h0, "status_cleared"); idle();

    // DONE set by the engine wins over a same-cycle write-1-to-clear
    wr(5'h18, 32'h1); idle();
    pulse_clear();
    wr(5'h1C, 32'h4);
    pulse_done();
    rd(5'h1C, 32'h4, "done_set_wins"); idle();
    wr(5'h1C, 32'h4); idle();

    // CLEAR_START with a same-cycle START in PENDING
    wr(5'h18, 32'h1); idle();
    wr(5'h18, 32'h1);
    pulse_clear();
    rd(5'h1C, 32'hA, "clear_vs_start"); idle();
    pulse_done();
    wr(5'h1C, 32'hC); idle();

    // Invalid descriptors
    wr(5'h00, 32'h0); wr(5'h18, 32'h1); idle();
    chk("size0_no_int", 32'(dma_int), 32'h0);
    rd(5'h1C, 32'h8, "size0_err"); idle();
    wr(5'h1C, 32'h8);
    wr(5'h00, 32'd3); wr(5'h0C, 32'hFFFF_FFFD); wr(5'h18, 32'h1); idle();
    chk("odd_des_no_int", 32'(dma_int), 32'h0);
    rd(5'h1C, 32'h8, "odd_des_err"); rd(5'h0C, 32'h1, "ed_mask"); rd(5'h00, 32'd3, "size_odd");
    idle();
    wr(5'h1C, 32'h8); idle();

    // Asynchronous reset while PENDING
    wr(5'h00, 32'd4); wr(5'h18, 32'h3); idle();
    chk("pending_int", 32'(dma_int), 32'h1);
    #3 rst_n = 1'b0;
    #1 chk("async_rst_int", 32'(dma_int), 32'h0);
    prev_rd = 1'b0; prev_wr = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Asynchronous reset while BUSY, caught in the middle of a read data phase
    wr(5'h00, 32'd4); wr(5'h04, 32'h0000_0011); wr(5'h18, 32'h3); idle();
    pulse_clear();
    rd(5'h04, 32'h0000_0011, "src_before_rst");
    prev_rd = 1'b0; prev_wr = 1'b0;
    drive_idle();
    #1 sb_pop();
    #1 rst_n = 1'b0;
    #1 chk("async_rst_hrdata", ahb.HRDATA, 32'h0);
    chk("async_rst_busy_int", 32'(dma_int), 32'h0);
    chk("async_rst_irq", 32'(dma_irq), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    read_all_zero("post_rst_reg");

    if (sb_exp.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_leftover: observed %0d pending reads expected 0", sb_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
